// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch input front end.
// Holds the debounce state encoding and the default timing constants.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int HOLD_CYCLES_DEF     = 200000000;
   localparam int CNT_W_DEF           = 20;

   // The debounced level is implied by the state: high only in PRESSED/RELEASE_WAIT.
   function automatic logic state_level(db_state_t s);
      return (s == PRESSED) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, mismatch counter and debounce FSM.
// Outputs the debounced level db and a one-cycle rise flag on each accepted press.
module debounce_channel
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if ((DEBOUNCE_CYCLES < 2) || ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_params
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
   end

   logic             sync1;
   logic             sync2;
   db_state_t        state;
   db_state_t        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             rise_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         rise  <= rise_next;
      end
   end

   // Any cycle where the synchronised value agrees with db clears the count,
   // so a glitch shorter than DEBOUNCE_CYCLES never reaches the flip.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      rise_next  = 1'b0;
      case (state)
         IDLE: begin
            if (sync2) begin
               state_next = PRESS_WAIT;
               cnt_next   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!sync2) begin
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_next = PRESSED;
               rise_next  = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync2) begin
               state_next = RELEASE_WAIT;
               cnt_next   = CNT_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (sync2) begin
               state_next = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign db = state_level(state);

endmodule

// File: rtl/button_conditioner.sv
// Board-input front end: debounces start/stop/reset buttons and the up switch.
// Optional long-hold clear on the reset button is built with STOPWATCH_HOLD_EN.
module button_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_start_raw,
   input  logic btn_stop_raw,
   input  logic btn_reset_raw,
   input  logic sw_up_raw,
   output logic start_pulse,
   output logic stop_pulse,
   output logic reset_pulse,
   output logic up_level,
   output logic clear_all_pulse
);

   logic start_db;
   logic start_rise;
   logic stop_db;
   logic stop_rise;
   logic reset_db;
   logic reset_rise;
   logic sw_db;
   logic sw_rise;

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_start_raw),
      .db    (start_db),
      .rise  (start_rise)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_stop (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_stop_raw),
      .db    (stop_db),
      .rise  (stop_rise)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_reset_raw),
      .db    (reset_db),
      .rise  (reset_rise)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_up_raw),
      .db    (sw_db),
      .rise  (sw_rise)
   );

   // Masked events are dropped outright: reset beats stop, stop beats start.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_pulse <= 1'b0;
         stop_pulse  <= 1'b0;
         reset_pulse <= 1'b0;
         up_level    <= 1'b0;
      end else begin
         reset_pulse <= reset_rise;
         stop_pulse  <= stop_rise & ~reset_rise;
         start_pulse <= start_rise & ~stop_rise & ~reset_rise;
         up_level    <= sw_db;
      end
   end

`ifdef STOPWATCH_HOLD_EN
   localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 2);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0] hold_cnt;

   // The counter parks one past HOLD_LAST so the clear fires once per press.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt        <= '0;
         clear_all_pulse <= 1'b0;
      end else begin
         clear_all_pulse <= reset_db && (hold_cnt == HOLD_LAST);
         if (!reset_db) begin
            hold_cnt <= '0;
         end else if (hold_cnt <= HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end
`else
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("button_conditioner: HOLD_CYCLES must be >= 1");
   end

   assign clear_all_pulse = 1'b0;
`endif

   logic unused_db;
   assign unused_db = ^{start_db, stop_db, reset_db, sw_rise};

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed table, corner sequences
// and randomized inputs checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int D = 4;
   localparam int H = 10;

   logic clk = 1'b0;
   logic reset;
   logic btn_start_raw;
   logic btn_stop_raw;
   logic btn_reset_raw;
   logic sw_up_raw;
   logic start_pulse;
   logic stop_pulse;
   logic reset_pulse;
   logic up_level;
   logic clear_all_pulse;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (4),
      .HOLD_CYCLES     (H)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .btn_start_raw   (btn_start_raw),
      .btn_stop_raw    (btn_stop_raw),
      .btn_reset_raw   (btn_reset_raw),
      .sw_up_raw       (sw_up_raw),
      .start_pulse     (start_pulse),
      .stop_pulse      (stop_pulse),
      .reset_pulse     (reset_pulse),
      .up_level        (up_level),
      .clear_all_pulse (clear_all_pulse)
   );

   // Reference model: a channel sees each raw sample two edges late, flips its
   // level once the last D seen samples all disagree with it, and a press shows
   // up on the outputs one edge after the flip, after priority masking.
   logic [3:0] m_db   = '0;
   logic [3:0] m_rise = '0;
   bit         rawq [4][$];
   bit         evq  [4][$];
   int         hold_run = 0;
   logic e_start = 1'b0, e_stop = 1'b0, e_reset = 1'b0, e_up = 1'b0, e_clear = 1'b0;

   always @(posedge clk) begin
      logic [3:0] raw_now;
      bit         seen;
      bit         all_diff;
      raw_now = {sw_up_raw, btn_reset_raw, btn_stop_raw, btn_start_raw};
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            rawq[i].delete();
            rawq[i].push_back(1'b0);
            rawq[i].push_back(1'b0);
            evq[i].delete();
         end
         m_db     = '0;
         m_rise   = '0;
         hold_run = 0;
         e_start  = 1'b0;
         e_stop   = 1'b0;
         e_reset  = 1'b0;
         e_up     = 1'b0;
         e_clear  = 1'b0;
      end else begin
         e_reset  = m_rise[2];
         e_stop   = m_rise[1] & ~m_rise[2];
         e_start  = m_rise[0] & ~m_rise[1] & ~m_rise[2];
         e_up     = m_db[3];
         hold_run = m_db[2] ? hold_run + 1 : 0;
`ifdef STOPWATCH_HOLD_EN
         e_clear  = (hold_run == H + 1);
`else
         e_clear  = 1'b0;
`endif
         m_rise = '0;
         for (int i = 0; i < 4; i++) begin
            seen = (rawq[i].size() > 1) ? rawq[i][1] : 1'b0;
            rawq[i].push_front(raw_now[i]);
            while (rawq[i].size() > 2) void'(rawq[i].pop_back());
            evq[i].push_front(seen);
            while (evq[i].size() > D) void'(evq[i].pop_back());
            all_diff = (evq[i].size() == D);
            for (int j = 0; j < evq[i].size(); j++) begin
               if (evq[i][j] == m_db[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
               m_db[i]   = ~m_db[i];
               m_rise[i] = m_db[i];
               evq[i].delete();
            end
         end
      end
   end

   task automatic checkBit(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkVal(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkBit({tag, ".start_pulse"},     start_pulse,     e_start);
      checkBit({tag, ".stop_pulse"},      stop_pulse,      e_stop);
      checkBit({tag, ".reset_pulse"},     reset_pulse,     e_reset);
      checkBit({tag, ".up_level"},        up_level,        e_up);
      checkBit({tag, ".clear_all_pulse"}, clear_all_pulse, e_clear);
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic p,
                                input logic rb, input logic sw);
      reset         = r;
      btn_start_raw = s;
      btn_stop_raw  = p;
      btn_reset_raw = rb;
      sw_up_raw     = sw;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
      checkOutput("model");
   endtask

   typedef struct {
      logic start, stop, rbtn, sw;
      logic e_start, e_stop, e_reset, e_up;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input int n, input logic s, input logic p, input logic rb,
                                  input logic sw, input logic es, input logic ep,
                                  input logic er, input logic eu);
      vec_t v;
      v = '{s, p, rb, sw, es, ep, er, eu};
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   initial begin
      int found;
      int count;
      int r_at;
      int c_at;
      int clears;

      // entry i drives the inputs sampled at edge i and holds the outputs seen after it
      addVec(6, 1, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 1, 0, 0, 0, 1, 0, 0, 0);
      addVec(3, 1, 0, 0, 0, 0, 0, 0, 0);
      addVec(8, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(3, 0, 1, 0, 0, 0, 0, 0, 0);
      addVec(8, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(6, 1, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 1, 1, 0, 0, 0, 1, 0, 0);
      addVec(2, 1, 1, 0, 0, 0, 0, 0, 0);
      addVec(8, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(6, 0, 0, 0, 1, 0, 0, 0, 0);
      addVec(4, 0, 0, 0, 1, 0, 0, 0, 1);
      addVec(6, 1, 1, 1, 1, 0, 0, 0, 1);
      addVec(1, 1, 1, 1, 1, 0, 0, 1, 1);
      addVec(3, 1, 1, 1, 1, 0, 0, 0, 1);
      addVec(8, 0, 0, 0, 1, 0, 0, 0, 1);
      addVec(6, 0, 0, 0, 0, 0, 0, 0, 1);
      addVec(4, 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(1, 0, 0, 0, 0);
      repeat (3) stepCycle();
      checkBit("reset.start_pulse", start_pulse, 1'b0);
      checkBit("reset.up_level",    up_level,    1'b0);
      applyStimulus(0, 0, 0, 0, 0);
      repeat (3) stepCycle();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(0, vecs[i].start, vecs[i].stop, vecs[i].rbtn, vecs[i].sw);
         stepCycle();
         checkBit($sformatf("vec%0d.start_pulse", i), start_pulse, vecs[i].e_start);
         checkBit($sformatf("vec%0d.stop_pulse", i),  stop_pulse,  vecs[i].e_stop);
         checkBit($sformatf("vec%0d.reset_pulse", i), reset_pulse, vecs[i].e_reset);
         checkBit($sformatf("vec%0d.up_level", i),    up_level,    vecs[i].e_up);
      end
      applyStimulus(0, 0, 0, 0, 0);
      repeat (10) stepCycle();

      // bouncing start button settles high; one pulse, 6 edges after the last rise
      applyStimulus(0, 1, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 1, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 1, 0, 0, 0);
      found = -1;
      count = 0;
      for (int n = 1; n <= 14; n++) begin
         stepCycle();
         if (start_pulse === 1'b1) begin
            count++;
            if (found < 0) found = n;
         end
      end
      checkVal("bounce.pulse_count", count, 1);
      checkVal("bounce.pulse_edge",  found, 7);
      applyStimulus(0, 0, 0, 0, 0);
      repeat (10) stepCycle();

      // reset arrives mid-debounce with the button still held
      applyStimulus(0, 1, 0, 0, 0);
      repeat (2) stepCycle();
      applyStimulus(1, 1, 0, 0, 0);
      repeat (3) stepCycle();
      checkBit("midreset.start_pulse", start_pulse, 1'b0);
      applyStimulus(0, 1, 0, 0, 0);
      found = -1;
      for (int n = 1; n <= 20; n++) begin
         stepCycle();
         if (start_pulse === 1'b1) begin
            found = n;
            break;
         end
      end
      checkVal("midreset.pulse_edge", found, 7);
      applyStimulus(0, 0, 0, 0, 0);
      repeat (10) stepCycle();

      // reset button held for 20 cycles
      applyStimulus(0, 0, 0, 1, 0);
      r_at   = -1;
      c_at   = -1;
      clears = 0;
      count  = 0;
      for (int n = 1; n <= 20; n++) begin
         stepCycle();
         if (reset_pulse === 1'b1) begin
            count++;
            r_at = n;
         end
         if (clear_all_pulse === 1'b1) begin
            clears++;
            c_at = n;
         end
      end
      checkVal("hold.reset_pulses", count, 1);
      checkVal("hold.reset_edge",   r_at,  7);
`ifdef STOPWATCH_HOLD_EN
      checkVal("hold.clear_pulses", clears,     1);
      checkVal("hold.clear_delay",  c_at - r_at, 10);
`else
      checkVal("hold.clear_pulses", clears, 0);
`endif
      applyStimulus(0, 0, 0, 0, 0);
      repeat (12) stepCycle();

      // randomized segments with occasional block resets
      for (int seg = 0; seg < 150; seg++) begin
         if ($urandom_range(99) < 4) begin
            applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(3, 1)) stepCycle();
         end
         applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(8, 1)) stepCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      repeat (10) stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side front end for the stopwatch controller. It takes the four raw asynchronous board inputs (start, stop and reset buttons, plus the up/down switch) and turns them into clean, clock-aligned commands. Each input is synchronised and debounced. The buttons then become single-cycle press pulses with fixed priority, and the switch becomes a stable level. It sits between the board pins and the controller's `start`/`stop`/`reset`/`up` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `HOLD_CYCLES`, 200000000: debounced-high cycles of the reset button before a long-hold event (2 s); used only with the macro.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high block reset.
- `btn_start_raw`  in  1  raw start button, asynchronous, active-high.
- `btn_stop_raw`  in  1  raw stop button.
- `btn_reset_raw`  in  1  raw reset button.
- `sw_up_raw`  in  1  raw direction switch; 1 = count up.
- `start_pulse`  out  1  one-cycle start command.
- `stop_pulse`  out  1  one-cycle stop command.
- `reset_pulse`  out  1  one-cycle reset command.
- `up_level`  out  1  debounced direction level.
- `clear_all_pulse`  out  1  one-cycle long-hold event on the reset button.

## Operation
- Each of the four inputs has its own 2-FF synchroniser, then a debounce channel holding a debounced state `db` and a counter `cnt`.
- Debounce rule, evaluated each cycle:
  - If the synchronised value equals `db`, `cnt` goes to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` and the mismatch persists, `db` flips and `cnt` goes to 0.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- Channel FSM: IDLE (db=0) → PRESS_WAIT (mismatch counting) → PRESSED (db=1) → RELEASE_WAIT → IDLE.
  - A mismatch that clears inside a WAIT state returns to the previous stable state.
- Buttons: a press event is `db` rising (0→1). It is registered into a one-cycle pulse. Releases produce nothing.
- Priority, applied in the same cycle:
  - `reset_pulse` masks `stop_pulse` and `start_pulse`.
  - `stop_pulse` masks `start_pulse`.
  - A masked event is dropped, not deferred.
- `up_level` is the switch channel's `db`, registered. The switch never produces a pulse.
- Holding a button produces exactly one pulse per press.

## Timing
- Reset values: all outputs 0; synchronisers 0; every `db` 0; every `cnt` 0; hold counter 0.
- Press latency: let edge k be the first edge at which sync stage 1 captures 1.
  - `db` rises at edge k+1+DEBOUNCE_CYCLES.
  - The pulse is high for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES.
- Release latency matches press latency. `up_level` reaches the new value after edge k+2+DEBOUNCE_CYCLES.
- Reset asserted mid-debounce aborts the count. If a button is still held when reset deasserts, it is treated as a fresh press and pulses after the full latency.
- Counter saturation is impossible by construction; the CNT_W constraint is checked at elaboration.

## Configuration
- `STOPWATCH_HOLD_EN` defined:
  - A hold counter increments while the reset channel's `db` is 1 and clears when `db` is 0.
  - When it reaches `HOLD_CYCLES`, `clear_all_pulse` goes high for one cycle. The counter then stops and does not fire again until release.
  - `reset_pulse` still fires at the start of the press.
- `STOPWATCH_HOLD_EN` undefined: no hold logic is built; `clear_all_pulse` is tied to 0.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the debounce FSM state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default constants `DEBOUNCE_CYCLES_DEF` and `HOLD_CYCLES_DEF`.
- Sub-module `debounce_channel` is instantiated four times. It contains the synchroniser, counter and FSM, and outputs `db` and `rise`.
- The top level contains only the priority masking, output registers and the optional hold counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.
- Clean press: `btn_start_raw` goes 1 before edge 0 and is held → `start_pulse` is high only in the cycle after edge 6; no further pulse while held.
- Glitch: `btn_stop_raw` is high for 3 cycles, then 0 → `stop_pulse` stays 0 throughout.
- Bounce: start button toggles 1,0,1,0 over 4 cycles, then stays 1 → exactly one `start_pulse`, 6 edges after the last rising edge.
- Simultaneous: start and stop pressed at the same edge → `stop_pulse`=1 and `start_pulse`=0. Adding reset at the same edge → only `reset_pulse`=1.
- Mid-operation reset: `reset` asserted 2 cycles into a start debounce while the button stays held → all outputs 0 during reset; one `start_pulse` 7 cycles after `reset` deasserts.
- Hold, with `STOPWATCH_HOLD_EN`: reset button held 20 cycles → one `reset_pulse`, then one `clear_all_pulse` 10 cycles later. Without the macro → `clear_all_pulse` stays 0.
